// File: rtl/user_la_capture.sv
// -----------------------------------------------------------------------------
// user_la_capture
//
// Logic-analyzer capture buffer for the Caravel user area. It waits for a
// masked trigger pattern on the 32-bit LA sample bus, then records DEPTH
// consecutive samples. The management core drains the buffer one word per
// pop event.
//
// Optional feature macro: LA_CAPTURE_DECIM_EN
//   When defined, la_data_in[47:40] (gated by la_oenb) sets a divisor D and
//   samples are stored every D+1 edges while capturing. When undefined,
//   those bits are ignored and every edge stores a sample.
//
// Ports
//   wb_clk_i     in   1    sole clock
//   wb_rst_i     in   1    synchronous active-high reset
//   la_data_in   in   128  [31:0] sample, [32] arm, [33] pop, [34] abort,
//                          [47:40] decimation, [95:64] trigger value,
//                          [127:96] trigger mask
//   la_oenb      in   128  control bit 32..47 honoured only while its bit is 0
//   la_data_out  out  128  [31:0] read data, [63:32] status, [127:64] zero
// -----------------------------------------------------------------------------
module user_la_capture #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [AW-1:0]    wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0]    rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic [2:0]       ctl_s, ctl_q_r, ctl_q2_r, ctl_evt_s;
  logic             arm_evt_s, pop_evt_s, abort_evt_s;
  logic [WIDTH-1:0] sample_s, trig_val_s, trig_mask_s;
  logic             trig_match_s;
  logic             sample_en_s;
  logic             mem_we_s;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_data_s;
  logic [31:0]      status_s;
  logic             full_s, empty_s;
  logic             unused_s;

  // Control bits read as 0 unless their output-enable-bar is low.
  assign ctl_s       = la_data_in[34:32] & ~la_oenb[34:32];
  assign ctl_evt_s   = ctl_q_r & ~ctl_q2_r;
  assign arm_evt_s   = ctl_evt_s[0];
  assign pop_evt_s   = ctl_evt_s[1];
  assign abort_evt_s = ctl_evt_s[2];

  assign sample_s     = la_data_in[WIDTH-1:0];
  assign trig_val_s   = la_data_in[64 +: WIDTH];
  assign trig_mask_s  = la_data_in[96 +: WIDTH];
  assign trig_match_s = ((sample_s & trig_mask_s) == (trig_val_s & trig_mask_s));

`ifdef LA_CAPTURE_DECIM_EN
  logic [7:0] decim_s, div_cnt_r, div_cnt_nxt_s;

  assign decim_s  = la_data_in[47:40] & ~la_oenb[47:40];
  assign unused_s = ^{la_data_in[63:48], la_data_in[39:35],
                      la_oenb[127:48], la_oenb[39:35], la_oenb[31:0]};

  // Divider: held at 0 outside CAPTURE so counting starts at the trigger edge.
  always_comb begin
    div_cnt_nxt_s = div_cnt_r;
    sample_en_s   = 1'b1;
    if (state_r == CAPTURE) begin
      if (div_cnt_r >= decim_s) begin
        sample_en_s   = 1'b1;
        div_cnt_nxt_s = 8'd0;
      end else begin
        sample_en_s   = 1'b0;
        div_cnt_nxt_s = div_cnt_r + 8'd1;
      end
    end else begin
      div_cnt_nxt_s = 8'd0;
    end
  end

  // Divider counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      div_cnt_r <= 8'd0;
    end else begin
      div_cnt_r <= div_cnt_nxt_s;
    end
  end
`else
  assign sample_en_s = 1'b1;
  assign unused_s    = ^{la_data_in[63:35], la_oenb[127:35], la_oenb[31:0]};
`endif

  // Next-state logic: abort beats arm, arm beats everything state-specific.
  always_comb begin
    state_nxt_s  = state_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    mem_we_s     = 1'b0;
    if (abort_evt_s) begin
      state_nxt_s = IDLE;
      count_nxt_s = {CW{1'b0}};
    end else if (arm_evt_s) begin
      state_nxt_s  = ARMED;
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = IDLE;
        end
        ARMED: begin
          if (trig_match_s) begin
            // The triggering sample itself is stored: no pre-trigger loss.
            mem_we_s     = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
            count_nxt_s  = CW'(1);
            if (CW'(DEPTH) == CW'(1)) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = CAPTURE;
            end
          end else begin
            state_nxt_s = ARMED;
          end
        end
        CAPTURE: begin
          if (sample_en_s) begin
            mem_we_s     = 1'b1;
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
            count_nxt_s  = count_r + CW'(1);
            if (count_r == CW'(DEPTH - 1)) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = CAPTURE;
            end
          end else begin
            state_nxt_s = CAPTURE;
          end
        end
        DONE: begin
          if (pop_evt_s && (count_r != {CW{1'b0}})) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
            count_nxt_s  = count_r - CW'(1);
            if (count_r == CW'(1)) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = DONE;
            end
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          count_nxt_s = {CW{1'b0}};
        end
      endcase
    end
  end

  // State, pointer, count and control-edge registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r  <= IDLE;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ctl_q_r  <= 3'b000;
      ctl_q2_r <= 3'b000;
    end else begin
      state_r  <= state_nxt_s;
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ctl_q_r  <= ctl_s;
      ctl_q2_r <= ctl_q_r;
    end
  end

  // Sample memory; contents are deliberately not reset.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we_s && !wb_rst_i) begin
      mem_r[wr_ptr_r] <= sample_s;
    end
  end

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign rd_data_s = ((state_r == DONE) && !empty_s) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign status_s  = {20'h0_0000, 8'(count_r), empty_s, full_s, state_r};

  assign la_data_out = {64'h0, status_s, rd_data_s};

endmodule

// File: tb/tb_user_la_capture.sv
module tb_user_la_capture;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] la_in = 128'h0;
  logic [127:0] la_oenb = 128'h0;
  logic [127:0] la_out;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit drive_cnt = 1'b0;

  // Reference model: expected buffer contents in capture order.
  logic [31:0] model_q[$];

  localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPT = 2'd2, S_DONE = 2'd3;

  user_la_capture #(.DEPTH(16), .WIDTH(32)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .la_data_in (la_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_out)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] st();
    return la_out[33:32];
  endfunction

  function automatic logic [7:0] cnt();
    return la_out[43:36];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (drive_cnt) la_in[31:0] = 32'(cyc);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
    int n = 0;
    while (st() != s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 128'(st()), 128'(s));
  endtask

  task automatic pulse(input int b);
    la_in[b] = 1'b1;
    tick();
    tick();
    la_in[b] = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_trig(input logic [31:0] val, input logic [31:0] mask);
    la_in[95:64]  = val;
    la_in[127:96] = mask;
  endtask

  // Pops n words, checking each read word against the model before popping.
  task automatic drain(input int n, input string tag);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      e = (model_q.size() > 0) ? model_q[0] : 32'hDEAD_BEEF;
      chk($sformatf("%s_data%0d", tag, i), 128'(la_out[31:0]), 128'(e));
      if (model_q.size() > 0) void'(model_q.pop_front());
      pulse(33);
      chk($sformatf("%s_cnt%0d", tag, i), 128'(cnt()), 128'(15 - i));
    end
  endtask

  // Arms with the current trigger, locks onto the trigger edge once ARMED is
  // seen, and fills the model with the counter values that follow at a stride.
  task automatic capture_counter(input int stride, input string tag);
    logic [31:0] first;
    drive_cnt = 1'b1;
    la_in[32] = 1'b1;
    wait_state(S_ARMED, 10, {tag, "_armed"});
    first = la_in[31:0];
    model_q.delete();
    for (int i = 0; i < 16; i++) model_q.push_back(first + 32'(i * stride));
    tick();
    la_in[32] = 1'b0;
    chk({tag, "_capt"}, 128'(st()), 128'(S_CAPT));
    wait_state(S_DONE, 16 * stride + 10, {tag, "_done"});
    chk({tag, "_full_cnt"}, 128'(la_out[43:34]), 128'({8'd16, 1'b0, 1'b1}));
  endtask

  initial begin
    logic [31:0] v;

    // Reset
    tick();
    tick();
    chk("reset", la_out, {64'h0, 32'h0000_0008, 32'h0});
    rst = 1'b0;
    tick();

    // Mask-0 capture then full drain
    set_trig(32'h0, 32'h0);
    capture_counter(1, "mask0");
    drain(16, "drain");
    chk("drain_end", la_out, {64'h0, 32'h0000_0008, 32'h0});
    pulse(33);
    chk("pop17", la_out, {64'h0, 32'h0000_0008, 32'h0});

    // Pattern trigger with random fill
    drive_cnt = 1'b0;
    la_in[31:0] = 32'h0000_1111;
    set_trig(32'hA5A5_0000, 32'hFFFF_0000);
    pulse(32);
    wait_state(S_ARMED, 10, "pat_armed");
    pulse(33);
    chk("pat_pop_ignored", 128'({st(), cnt()}), 128'({S_ARMED, 8'd0}));
    la_in[31:0] = 32'hA5A4_0000 | 32'($urandom_range(0, 16'hFFFF));
    tick();
    chk("pat_pre_nomatch", 128'(st()), 128'(S_ARMED));
    model_q.delete();
    la_in[31:0] = 32'hA5A5_1234;
    model_q.push_back(32'hA5A5_1234);
    tick();
    for (int i = 1; i < 16; i++) begin
      v = $urandom();
      la_in[31:0] = v;
      model_q.push_back(v);
      tick();
    end
    chk("pat_done", 128'(st()), 128'(S_DONE));
    drain(16, "pat");
    chk("pat_idle", 128'(st()), 128'(S_IDLE));

    // Abort during capture at count 5
    set_trig(32'h0, 32'h0);
    drive_cnt = 1'b1;
    la_in[32] = 1'b1;
    for (int n = 0; n < 30 && cnt() != 8'd5; n++) tick();
    chk("abort_at5", 128'({st(), cnt()}), 128'({S_CAPT, 8'd5}));
    la_in[34] = 1'b1;
    wait_state(S_IDLE, 10, "abort_idle");
    chk("abort_empty", 128'(la_out[43:35]), 128'({8'd0, 1'b1}));
    la_in[34] = 1'b0;
    la_in[32] = 1'b0;
    tick();
    tick();

    // Arm in DONE with count 10 restarts empty in ARMED
    capture_counter(1, "rearm");
    for (int i = 0; i < 6; i++) pulse(33);
    chk("rearm_cnt10", 128'({st(), cnt()}), 128'({S_DONE, 8'd10}));
    set_trig(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    pulse(32);
    chk("rearm_armed", la_out, {64'h0, 32'h0000_0009, 32'h0});

    // Simultaneous arm and abort from ARMED: abort wins
    la_in[32] = 1'b1;
    la_in[34] = 1'b1;
    tick();
    tick();
    tick();
    chk("arm_abort", 128'(st()), 128'(S_IDLE));
    la_in[32] = 1'b0;
    la_in[34] = 1'b0;
    tick();
    tick();
    chk("arm_abort_hold", 128'(st()), 128'(S_IDLE));

    // Gated arm has no effect
    la_oenb[32] = 1'b1;
    set_trig(32'h0, 32'h0);
    pulse(32);
    pulse(32);
    chk("gated_arm", la_out, {64'h0, 32'h0000_0008, 32'h0});
    la_oenb[32] = 1'b0;
    tick();

    // Reset mid-capture discards everything
    la_in[32] = 1'b1;
    wait_state(S_CAPT, 10, "midrst_capt");
    la_in[32] = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst", la_out, {64'h0, 32'h0000_0008, 32'h0});
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_after", la_out, {64'h0, 32'h0000_0008, 32'h0});

    // Decimation divisor D=3 (stride 4 only when the feature is built in)
    la_in[47:40] = 8'd3;
`ifdef LA_CAPTURE_DECIM_EN
    capture_counter(4, "decim");
`else
    capture_counter(1, "nodecim");
`endif
    drain(16, "dec");
    la_in[47:40] = 8'd0;
    chk("final_idle", 128'(st()), 128'(S_IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
